// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetch unit sitting between the memory controller and the decoder.
//   It keeps at most one fetch request outstanding. Returned instructions are
//   buffered in a QUEUE_DEPTH-entry FIFO; each entry is tagged with its PC and a
//   prediction. A flush redirects fetch and discards both the queue and any
//   in-flight response.
//
//   Optional feature: define FETCH_STATIC_BP_EN to enable static branch prediction.
//   With it, backward B-type branches and JAL are predicted taken. Without it,
//   every instruction is predicted not taken with a next PC of PC+4.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (global enable; low freezes all state)
//   mc_to_if_inst / mc_to_if_ready      : memory response (one-cycle pulse)
//   if_to_mc_ready / if_to_mc_PC        : fetch request
//   flush_in / flush_PC                 : redirect
//   dc_to_if_ready                      : decoder accepts the head entry
//   if_to_dc_valid/_inst/_PC/_pred_taken/_pred_PC : head entry presented to the decoder

module fetch_queue_unit #(
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         INST_W      = 32,
    parameter int unsigned         QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [INST_W-1:0] mc_to_if_inst,
    input  logic              mc_to_if_ready,
    output logic              if_to_mc_ready,
    output logic [ADDR_W-1:0] if_to_mc_PC,
    input  logic              flush_in,
    input  logic [ADDR_W-1:0] flush_PC,
    input  logic              dc_to_if_ready,
    output logic              if_to_dc_valid,
    output logic [INST_W-1:0] if_to_dc_inst,
    output logic [ADDR_W-1:0] if_to_dc_PC,
    output logic              if_to_dc_pred_taken,
    output logic [ADDR_W-1:0] if_to_dc_pred_PC
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] ppc;
    } entry_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_n;
    logic [PTR_W-1:0]  head_q, head_n, tail_q, tail_n;
    logic [CNT_W-1:0]  count_q, count_n;
    entry_t            mem_q [QUEUE_DEPTH];

    logic              mc_req_q, mc_req_n;
    logic [ADDR_W-1:0] mc_pc_q, mc_pc_n;
    logic              dc_valid_q, dc_valid_n;
    entry_t            dc_head_q, dc_head_n;

    logic              push, pop;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_pc;
    entry_t            new_entry;

    // Static prediction for the instruction currently returning from memory
`ifdef FETCH_STATIC_BP_EN
    logic [31:0] imm_b, imm_j;

    always_comb begin
        imm_b      = {{20{mc_to_if_inst[31]}}, mc_to_if_inst[7], mc_to_if_inst[30:25],
                      mc_to_if_inst[11:8], 1'b0};
        imm_j      = {{12{mc_to_if_inst[31]}}, mc_to_if_inst[19:12], mc_to_if_inst[20],
                      mc_to_if_inst[30:21], 1'b0};
        pred_taken = 1'b0;
        pred_pc    = fetch_pc_q + ADDR_W'(4);
        if (mc_to_if_inst[6:0] == 7'b1100011 && mc_to_if_inst[31]) begin
            // sign bit set means negative offset: backward branch, predict taken
            pred_taken = 1'b1;
            pred_pc    = fetch_pc_q + ADDR_W'($signed(imm_b));
        end else if (mc_to_if_inst[6:0] == 7'b1101111) begin
            pred_taken = 1'b1;
            pred_pc    = fetch_pc_q + ADDR_W'($signed(imm_j));
        end
    end
`else
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = fetch_pc_q + ADDR_W'(4);
    end
`endif

    always_comb begin
        new_entry.inst  = mc_to_if_inst;
        new_entry.pc    = fetch_pc_q;
        new_entry.taken = pred_taken;
        new_entry.ppc   = pred_pc;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        push       = 1'b0;
        pop        = dc_valid_q & dc_to_if_ready & ~flush_in;

        unique case (state_q)
            S_IDLE: begin
                if (flush_in) begin
                    fetch_pc_n = flush_PC;
                end else if (count_q < CNT_W'(QUEUE_DEPTH)) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_in) begin
                    fetch_pc_n = flush_PC;
                    // a response arriving with the flush is the stale one
                    state_n    = mc_to_if_ready ? S_IDLE : S_DROP;
                end else if (mc_to_if_ready) begin
                    push       = 1'b1;
                    fetch_pc_n = pred_pc;
                    state_n    = S_IDLE;
                end
            end
            S_DROP: begin
                if (flush_in) begin
                    fetch_pc_n = flush_PC;
                end
                if (mc_to_if_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        tail_n  = tail_q + PTR_W'(push);
        head_n  = flush_in ? tail_q : head_q + PTR_W'(pop);
        count_n = flush_in ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);

        // request stays visible (with its original PC) until the response, even if dropped
        mc_req_n = (state_n != S_IDLE);
        if (state_q == S_IDLE && state_n == S_WAIT) begin
            mc_pc_n = fetch_pc_q;
        end else if (state_n == S_IDLE) begin
            mc_pc_n = fetch_pc_n;
        end else begin
            mc_pc_n = mc_pc_q;
        end

        // head register: bypass the entry being written when it becomes the head
        dc_valid_n = (count_n != '0);
        if (push && tail_q == head_n) begin
            dc_head_n = new_entry;
        end else begin
            dc_head_n = mem_q[head_n];
        end
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mc_req_q   <= 1'b0;
            mc_pc_q    <= RESET_PC;
            dc_valid_q <= 1'b0;
            dc_head_q  <= '0;
        end else if (rdy_in) begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            count_q    <= count_n;
            mc_req_q   <= mc_req_n;
            mc_pc_q    <= mc_pc_n;
            dc_valid_q <= dc_valid_n;
            dc_head_q  <= dc_head_n;
        end
    end

    // Queue storage; contents only matter while count covers them
    always_ff @(posedge clk_in) begin
        if (rdy_in && push) begin
            mem_q[tail_q] <= new_entry;
        end
    end

    assign if_to_mc_ready      = mc_req_q;
    assign if_to_mc_PC         = mc_pc_q;
    assign if_to_dc_valid      = dc_valid_q;
    assign if_to_dc_inst       = dc_head_q.inst;
    assign if_to_dc_PC         = dc_head_q.pc;
    assign if_to_dc_pred_taken = dc_head_q.taken;
    assign if_to_dc_pred_PC    = dc_head_q.ppc;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fetch_queue_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mc_to_if_inst;
    logic        mc_to_if_ready;
    logic        if_to_mc_ready;
    logic [31:0] if_to_mc_PC;
    logic        flush_in;
    logic [31:0] flush_PC;
    logic        dc_to_if_ready;
    logic        if_to_dc_valid;
    logic [31:0] if_to_dc_inst;
    logic [31:0] if_to_dc_PC;
    logic        if_to_dc_pred_taken;
    logic [31:0] if_to_dc_pred_PC;

    fetch_queue_unit dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .mc_to_if_inst       (mc_to_if_inst),
        .mc_to_if_ready      (mc_to_if_ready),
        .if_to_mc_ready      (if_to_mc_ready),
        .if_to_mc_PC         (if_to_mc_PC),
        .flush_in            (flush_in),
        .flush_PC            (flush_PC),
        .dc_to_if_ready      (dc_to_if_ready),
        .if_to_dc_valid      (if_to_dc_valid),
        .if_to_dc_inst       (if_to_dc_inst),
        .if_to_dc_PC         (if_to_dc_PC),
        .if_to_dc_pred_taken (if_to_dc_pred_taken),
        .if_to_dc_pred_PC    (if_to_dc_pred_PC)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        bit          taken;
        logic [31:0] ppc;
    } ent_t;

    // reference model
    ent_t        q[$];
    logic [31:0] m_pc;        // next address to fetch
    bit          m_out;       // a request is outstanding
    bit          m_stale;     // outstanding request was flushed
    logic [31:0] m_req_pc;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Prediction straight from the immediate arithmetic
    function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                    output bit tk, output logic [31:0] npc);
        tk  = 1'b0;
        npc = pc + 32'd4;
`ifdef FETCH_STATIC_BP_EN
        begin
            int imm;
            if (inst[6:0] == 7'b1100011) begin
                imm = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
                    + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
                if (imm < 0) begin
                    tk  = 1'b1;
                    npc = pc + 32'(imm);
                end
            end else if (inst[6:0] == 7'b1101111) begin
                imm = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096
                    + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
                tk  = 1'b1;
                npc = pc + 32'(imm);
            end
        end
`endif
    endfunction

    // Drive one cycle, advance the model, and compare every output
    task automatic step(input bit rdy, input bit resp, input logic [31:0] inst,
                        input bit dc, input bit fl, input logic [31:0] fpc);
        int   n0;
        ent_t e;
        rdy_in         = rdy;
        mc_to_if_ready = resp;
        mc_to_if_inst  = inst;
        dc_to_if_ready = dc;
        flush_in       = fl;
        flush_PC       = fpc;
        @(posedge clk_in);
        if (rdy) begin
            n0 = q.size();
            if (fl) begin
                q.delete();
                m_pc = fpc;
                if (m_out && resp) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else if (m_out) begin
                    m_stale = 1'b1;
                end
            end else begin
                if (dc && n0 > 0) void'(q.pop_front());
                if (m_out) begin
                    if (resp) begin
                        if (!m_stale) begin
                            e.inst = inst;
                            e.pc   = m_pc;
                            predict(inst, m_pc, e.taken, e.ppc);
                            q.push_back(e);
                            m_pc = e.ppc;
                        end
                        m_out   = 1'b0;
                        m_stale = 1'b0;
                    end
                end else if (n0 < DEPTH) begin
                    m_out    = 1'b1;
                    m_req_pc = m_pc;
                end
            end
        end
        #1;
        check("mc_req", 64'(if_to_mc_ready), 64'(m_out));
        check("mc_pc", 64'(if_to_mc_PC), 64'(m_out ? m_req_pc : m_pc));
        check("dc_valid", 64'(if_to_dc_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("dc_inst", 64'(if_to_dc_inst), 64'(q[0].inst));
            check("dc_pc", 64'(if_to_dc_PC), 64'(q[0].pc));
            check("dc_taken", 64'(if_to_dc_pred_taken), 64'(q[0].taken));
            check("dc_ppc", 64'(if_to_dc_pred_PC), 64'(q[0].ppc));
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return {r[31:7], 7'b1100011};
            1: return {r[31:7], 7'b1101111};
            2: return {r[31:7], 7'b1100111};
            default: return r;
        endcase
    endfunction

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; mc_to_if_inst = '0; mc_to_if_ready = 1'b0;
        flush_in = 1'b0; flush_PC = '0; dc_to_if_ready = 1'b0;
        m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_req_pc = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_mc_req", 64'(if_to_mc_ready), 64'd0);
        check("rst_mc_pc", 64'(if_to_mc_PC), 64'h0);
        check("rst_dc_valid", 64'(if_to_dc_valid), 64'd0);
        check("rst_dc_taken", 64'(if_to_dc_pred_taken), 64'd0);
        check("rst_dc_ppc", 64'(if_to_dc_pred_PC), 64'd0);
        rst_in = 1'b1;

        // fill the queue with four responses, decoder stalled
        step(1, 0, NOP, 0, 0, 0);
        check("first_req", 64'({if_to_mc_ready, if_to_mc_PC}), {31'd0, 1'b1, 32'h0});
        for (int k = 0; k < 4; k++) begin
            step(1, 1, NOP, 0, 0, 0);
            step(1, 0, NOP, 0, 0, 0);
        end
        step(1, 0, NOP, 0, 0, 0);
        check("full_no_req", 64'(if_to_mc_ready), 64'd0);
        check("full_head_pc", 64'(if_to_dc_PC), 64'h0);

        // one pop frees a slot; request for 0x10 follows
        step(1, 0, NOP, 1, 0, 0);
        check("pop_head_pc", 64'(if_to_dc_PC), 64'h4);
        step(1, 0, NOP, 0, 0, 0);
        check("req_after_pop", 64'({if_to_mc_ready, if_to_mc_PC}), {31'd0, 1'b1, 32'h10});

        // flush while waiting; stale response dropped
        step(1, 0, NOP, 0, 1, 32'h200);
        check("flush_empty", 64'(if_to_dc_valid), 64'd0);
        step(1, 1, NOP, 0, 0, 0);
        check("drop_no_push", 64'(if_to_dc_valid), 64'd0);
        step(1, 0, NOP, 0, 0, 0);
        check("req_flush_pc", 64'(if_to_mc_PC), 64'h200);

        // flush coincident with response
        step(1, 1, NOP, 0, 1, 32'h300);
        check("flush_resp_no_push", 64'(if_to_dc_valid), 64'd0);
        step(1, 0, NOP, 0, 0, 0);
        check("req_flush_resp_pc", 64'(if_to_mc_PC), 64'h300);

        // backward BEQ at 0x100
        step(1, 0, NOP, 0, 1, 32'h100);
        step(1, 1, NOP, 0, 0, 0);
        step(1, 0, NOP, 0, 0, 0);
        step(1, 1, 32'hFE00_0EE3, 0, 0, 0);
`ifdef FETCH_STATIC_BP_EN
        check("beq_taken", 64'(if_to_dc_pred_taken), 64'd1);
        check("beq_ppc", 64'(if_to_dc_pred_PC), 64'h0FC);
        step(1, 0, NOP, 0, 0, 0);
        check("beq_next_req", 64'(if_to_mc_PC), 64'h0FC);
`else
        check("beq_taken", 64'(if_to_dc_pred_taken), 64'd0);
        check("beq_ppc", 64'(if_to_dc_pred_PC), 64'h104);
        step(1, 0, NOP, 0, 0, 0);
        check("beq_next_req", 64'(if_to_mc_PC), 64'h104);
`endif

        // PC wrap at the top of the address space
        step(1, 0, NOP, 1, 1, 32'hFFFF_FFFC);
        step(1, 1, NOP, 0, 0, 0);
        step(1, 0, NOP, 0, 0, 0);
        step(1, 1, NOP, 0, 0, 0);
        step(1, 0, NOP, 0, 0, 0);
        check("wrap_req", 64'({if_to_mc_ready, if_to_mc_PC}), {31'd0, 1'b1, 32'h0});

        // rdy_in low mid-WAIT freezes everything, even flush and pop
        for (int k = 0; k < 3; k++) begin
            step(0, 0, NOP, 1, 1, 32'h400);
            check("frozen_req", 64'({if_to_mc_ready, if_to_mc_PC}), {31'd0, 1'b1, 32'h0});
            check("frozen_head", 64'(if_to_dc_PC), 64'hFFFF_FFFC);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rdy, resp, dc, fl;
            rdy  = ($urandom_range(0, 7) != 0);
            resp = m_out && rdy && ($urandom_range(0, 2) == 0);
            dc   = ($urandom_range(0, 1) == 1);
            fl   = ($urandom_range(0, 19) == 0);
            step(rdy, resp, rand_inst(), dc, fl, $urandom & 32'hFFFF_FFFC);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
